// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and baud timing helpers
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    function automatic int uart_cpb(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int uart_cnt_width(input int cpb);
        return $clog2(cpb + 1);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and parallel word signals of the UART receiver
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  frame_err;
    logic                  rx_busy;

    modport master (
        output rx,
        input  dout,
        input  dout_valid,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx,
        output dout,
        output dout_valid,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser with falling-edge detect
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);
    logic rx_meta;
    logic rx_q;

    // Reset to the idle level so a line already low at release reads as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    assign fall = rx_q & ~rx_s;
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - LSB-first UART receiver with fixed-divider baud timing
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 125_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int STOP_BITS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    uart_rx_if.slave    bus
);
    localparam int CPB  = uart_cpb(CLK_FREQ, BAUD_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = uart_cnt_width(CPB);
    localparam int BW   = $clog2(DATA_WIDTH + 3);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_rx: STOP_BITS must be 1 or 2");
    end

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (bus.rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    uart_state_t           state,     state_n;
    logic [CW-1:0]         cycle_cnt, cycle_cnt_n;
    logic [BW-1:0]         bit_cnt,   bit_cnt_n;
    logic [DATA_WIDTH-1:0] shreg,     shreg_n;
    logic [DATA_WIDTH-1:0] dout_r,    dout_n;
    logic                  err,       err_n;
    logic                  valid_r,   valid_n;
    logic                  ferr_r,    ferr_n;
    logic [DATA_WIDTH:0]   shift_cat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            dout_r    <= '0;
            err       <= 1'b0;
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            state     <= state_n;
            cycle_cnt <= cycle_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            dout_r    <= dout_n;
            err       <= err_n;
            valid_r   <= valid_n;
            ferr_r    <= ferr_n;
        end
    end

    always_comb begin
        state_n     = state;
        cycle_cnt_n = cycle_cnt;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        dout_n      = dout_r;
        err_n       = err;
        valid_n     = 1'b0;
        ferr_n      = 1'b0;
        shift_cat   = {rx_s, shreg};

        case (state)
            IDLE: begin
                cycle_cnt_n = '0;
                bit_cnt_n   = '0;
                err_n       = 1'b0;
                if (fall) begin
                    state_n = START;
                end
            end
            START: begin
                if (cycle_cnt == CW'(HALF - 1)) begin
                    cycle_cnt_n = '0;
                    state_n     = rx_s ? IDLE : DATA;
                end else begin
                    cycle_cnt_n = cycle_cnt + CW'(1);
                end
            end
            DATA: begin
                if (cycle_cnt == CW'(CPB - 1)) begin
                    cycle_cnt_n = '0;
                    shreg_n     = shift_cat[DATA_WIDTH:1];
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end else begin
                    cycle_cnt_n = cycle_cnt + CW'(1);
                end
            end
            STOP: begin
                if (cycle_cnt == CW'(CPB - 1)) begin
                    cycle_cnt_n = '0;
                    err_n       = err | ~rx_s;
                    // Leave at mid-stop so an immediately following start edge is not missed.
                    if (bit_cnt == BW'(STOP_BITS - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                        if (err || !rx_s) begin
                            ferr_n = 1'b1;
                        end else begin
                            valid_n = 1'b1;
                            dout_n  = shreg;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end else begin
                    cycle_cnt_n = cycle_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = valid_r;
    assign bus.frame_err  = ferr_r;
    assign bus.rx_busy    = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if #(.DATA_WIDTH(8)) bus1 ();
    uart_rx_if #(.DATA_WIDTH(8)) bus2 ();

    uart_rx #(.DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );
    uart_rx #(.DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave)
    );

    int v1_n = 0, f1_n = 0, v2_n = 0, f2_n = 0, both_n = 0;
    int v1_cyc [64];
    int f1_cyc [64];
    int v2_cyc [64];
    int f2_cyc [64];
    logic [7:0] v1_dat [64];
    logic [7:0] v2_dat [64];
    logic b1_prev = 1'b0;
    int   b1_rise = -1, b1_fall = -1;

    always @(negedge clk) begin
        if (bus1.dout_valid === 1'b1) begin
            v1_cyc[v1_n % 64] <= cyc;
            v1_dat[v1_n % 64] <= bus1.dout;
            v1_n <= v1_n + 1;
        end
        if (bus1.frame_err === 1'b1) begin
            f1_cyc[f1_n % 64] <= cyc;
            f1_n <= f1_n + 1;
        end
        if (bus2.dout_valid === 1'b1) begin
            v2_cyc[v2_n % 64] <= cyc;
            v2_dat[v2_n % 64] <= bus2.dout;
            v2_n <= v2_n + 1;
        end
        if (bus2.frame_err === 1'b1) begin
            f2_cyc[f2_n % 64] <= cyc;
            f2_n <= f2_n + 1;
        end
        if ((bus1.dout_valid === 1'b1 && bus1.frame_err === 1'b1) ||
            (bus2.dout_valid === 1'b1 && bus2.frame_err === 1'b1))
            both_n <= both_n + 1;
        b1_prev <= (bus1.rx_busy === 1'b1);
        if (bus1.rx_busy === 1'b1 && !b1_prev) b1_rise <= cyc;
        if (bus1.rx_busy !== 1'b1 && b1_prev)  b1_fall <= cyc;
    end

    task automatic set_rx(input int which, input logic b);
        if (which == 1) bus1.rx = b;
        else            bus2.rx = b;
    endtask

    // Called at a negedge; returns at a negedge with the line back at idle.
    task automatic send_frame(input int which, input logic [7:0] d, input logic s0,
                              input logic s1, input int nstop, output int k);
        k = cyc + 1;
        set_rx(which, 1'b0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, d[i]);
            repeat (10) @(negedge clk);
        end
        set_rx(which, s0);
        repeat (10) @(negedge clk);
        if (nstop == 2) begin
            set_rx(which, s1);
            repeat (10) @(negedge clk);
        end
        set_rx(which, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus1.dout !== 8'h00) begin failures++; $display("FAIL reset_dout1 got=%0h exp=00", bus1.dout); end
        checks++; if (bus1.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid1 got=%b exp=0", bus1.dout_valid); end
        checks++; if (bus1.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr1 got=%b exp=0", bus1.frame_err); end
        checks++; if (bus1.rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%b exp=0", bus1.rx_busy); end
        checks++; if (bus2.dout !== 8'h00) begin failures++; $display("FAIL reset_dout2 got=%0h exp=00", bus2.dout); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_frame;
        int k, n0, f0;
        n0 = v1_n; f0 = f1_n;
        send_frame(1, 8'hA5, 1'b1, 1'b1, 1, k);
        repeat (5) @(negedge clk);
        checks++; if (v1_n - n0 !== 1) begin failures++; $display("FAIL frame_valid_cycles got=%0d exp=1", v1_n - n0); end
        checks++; if (v1_cyc[n0] !== k + 97) begin failures++; $display("FAIL frame_valid_edge got=%0d exp=%0d", v1_cyc[n0] - k, 97); end
        checks++; if (v1_dat[n0] !== 8'hA5) begin failures++; $display("FAIL frame_dout got=%0h exp=a5", v1_dat[n0]); end
        checks++; if (f1_n !== f0) begin failures++; $display("FAIL frame_no_ferr got=%0d exp=0", f1_n - f0); end
        checks++; if (b1_rise !== k + 2) begin failures++; $display("FAIL frame_busy_rise got=%0d exp=2", b1_rise - k); end
        checks++; if (b1_fall !== k + 97) begin failures++; $display("FAIL frame_busy_fall got=%0d exp=97", b1_fall - k); end
    endtask

    task automatic test_framing_err;
        int k, n0, f0;
        n0 = v1_n; f0 = f1_n;
        send_frame(1, 8'h3C, 1'b0, 1'b1, 1, k);
        repeat (5) @(negedge clk);
        checks++; if (f1_n - f0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", f1_n - f0); end
        checks++; if (f1_cyc[f0] !== k + 97) begin failures++; $display("FAIL ferr_edge got=%0d exp=97", f1_cyc[f0] - k); end
        checks++; if (v1_n !== n0) begin failures++; $display("FAIL ferr_no_valid got=%0d exp=0", v1_n - n0); end
        checks++; if (bus1.dout !== 8'hA5) begin failures++; $display("FAIL ferr_dout_held got=%0h exp=a5", bus1.dout); end
    endtask

    task automatic test_back_to_back;
        int k1, k2, n0;
        n0 = v1_n;
        send_frame(1, 8'h00, 1'b1, 1'b1, 1, k1);
        send_frame(1, 8'hFF, 1'b1, 1'b1, 1, k2);
        repeat (5) @(negedge clk);
        checks++; if (v1_n - n0 !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", v1_n - n0); end
        checks++; if (v1_cyc[n0] !== k1 + 97) begin failures++; $display("FAIL b2b_first_edge got=%0d exp=97", v1_cyc[n0] - k1); end
        checks++; if (v1_cyc[n0 + 1] - v1_cyc[n0] !== 100) begin failures++; $display("FAIL b2b_spacing got=%0d exp=100", v1_cyc[n0 + 1] - v1_cyc[n0]); end
        checks++; if (v1_dat[n0] !== 8'h00) begin failures++; $display("FAIL b2b_data0 got=%0h exp=00", v1_dat[n0]); end
        checks++; if (v1_dat[n0 + 1] !== 8'hFF) begin failures++; $display("FAIL b2b_data1 got=%0h exp=ff", v1_dat[n0 + 1]); end
    endtask

    task automatic test_glitch;
        int k, n0, f0;
        n0 = v1_n; f0 = f1_n;
        k = cyc + 1;
        bus1.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus1.rx = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (b1_rise !== k + 2) begin failures++; $display("FAIL glitch_busy_rise got=%0d exp=2", b1_rise - k); end
        checks++; if (b1_fall !== k + 7) begin failures++; $display("FAIL glitch_busy_fall got=%0d exp=7", b1_fall - k); end
        checks++; if (v1_n !== n0) begin failures++; $display("FAIL glitch_no_valid got=%0d exp=0", v1_n - n0); end
        checks++; if (f1_n !== f0) begin failures++; $display("FAIL glitch_no_ferr got=%0d exp=0", f1_n - f0); end
    endtask

    task automatic test_break;
        int k, n0, f0;
        n0 = v1_n; f0 = f1_n;
        k = cyc + 1;
        bus1.rx = 1'b0;
        repeat (300) @(negedge clk);
        bus1.rx = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (f1_n - f0 !== 1) begin failures++; $display("FAIL break_ferr_count got=%0d exp=1", f1_n - f0); end
        checks++; if (f1_cyc[f0] !== k + 97) begin failures++; $display("FAIL break_ferr_edge got=%0d exp=97", f1_cyc[f0] - k); end
        checks++; if (v1_n !== n0) begin failures++; $display("FAIL break_no_valid got=%0d exp=0", v1_n - n0); end
        checks++; if (bus1.rx_busy !== 1'b0) begin failures++; $display("FAIL break_idle got=%b exp=0", bus1.rx_busy); end
        checks++; if (bus1.dout !== 8'hFF) begin failures++; $display("FAIL break_dout_held got=%0h exp=ff", bus1.dout); end
    endtask

    task automatic test_two_stop;
        int k, n0, f0;
        n0 = v2_n; f0 = f2_n;
        send_frame(2, 8'h33, 1'b1, 1'b1, 2, k);
        repeat (5) @(negedge clk);
        checks++; if (v2_n - n0 !== 1) begin failures++; $display("FAIL stop2_good_count got=%0d exp=1", v2_n - n0); end
        checks++; if (v2_cyc[n0] !== k + 107) begin failures++; $display("FAIL stop2_good_edge got=%0d exp=107", v2_cyc[n0] - k); end
        checks++; if (v2_dat[n0] !== 8'h33) begin failures++; $display("FAIL stop2_good_dout got=%0h exp=33", v2_dat[n0]); end
        n0 = v2_n;
        send_frame(2, 8'h5A, 1'b1, 1'b0, 2, k);
        repeat (5) @(negedge clk);
        checks++; if (f2_n - f0 !== 1) begin failures++; $display("FAIL stop2_ferr_count got=%0d exp=1", f2_n - f0); end
        checks++; if (f2_cyc[f0] !== k + 107) begin failures++; $display("FAIL stop2_ferr_edge got=%0d exp=107", f2_cyc[f0] - k); end
        checks++; if (v2_n !== n0) begin failures++; $display("FAIL stop2_no_valid got=%0d exp=0", v2_n - n0); end
        checks++; if (bus2.dout !== 8'h33) begin failures++; $display("FAIL stop2_dout_held got=%0h exp=33", bus2.dout); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        int k, n0, f0;
        d = 8'h81;
        n0 = v1_n; f0 = f1_n;
        bus1.rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus1.rx = d[i];
            repeat (10) @(negedge clk);
        end
        bus1.rx = d[4];
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bus1.rx = 1'b1;
        @(negedge clk);
        checks++; if (bus1.dout !== 8'h00) begin failures++; $display("FAIL rstmid_dout got=%0h exp=00", bus1.dout); end
        checks++; if (bus1.rx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus1.rx_busy); end
        checks++; if (bus1.dout_valid !== 1'b0 || bus1.frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_pulses got=%b%b exp=00", bus1.dout_valid, bus1.frame_err); end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (v1_n !== n0 || f1_n !== f0) begin failures++; $display("FAIL rstmid_no_pulse got=%0d/%0d exp=0/0", v1_n - n0, f1_n - f0); end
        send_frame(1, 8'h81, 1'b1, 1'b1, 1, k);
        repeat (5) @(negedge clk);
        checks++; if (v1_n - n0 !== 1) begin failures++; $display("FAIL rstmid_after_count got=%0d exp=1", v1_n - n0); end
        checks++; if (bus1.dout !== 8'h81) begin failures++; $display("FAIL rstmid_after_dout got=%0h exp=81", bus1.dout); end
        checks++; if (v1_cyc[n0] !== k + 97) begin failures++; $display("FAIL rstmid_after_edge got=%0d exp=97", v1_cyc[n0] - k); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus1.rx = 1'b1;
        bus2.rx = 1'b1;
        @(negedge clk);
        test_reset;
        test_frame;
        test_framing_err;
        test_back_to_back;
        test_glitch;
        test_break;
        test_two_stop;
        test_reset_mid;
        checks++; if (both_n !== 0) begin failures++; $display("FAIL exclusive_pulses got=%0d exp=0", both_n); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
